// File: rtl/note_sequencer.sv
// Queues note commands and plays them one at a time on an envelope channel with an optional rest gap.
// Push to env_trig is 3 cycles when idle; cmd_ready drops while the DEPTH-entry command queue is full.
module note_sequencer #(
    parameter int DEPTH   = 4,
    parameter int PITCH_W = 8,
    parameter int GAP_W   = 4
) (
    input  logic               note_clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PITCH_W-1:0] cmd_pitch,
    input  logic [1:0]         cmd_attack,
    input  logic [1:0]         cmd_decay,
    input  logic [2:0]         cmd_length,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic               cmd_rest,
    output logic [1:0]         env_attack,
    output logic [1:0]         env_decay,
    output logic [2:0]         env_length,
    output logic               env_trig,
    input  logic               env_enable,
    output logic [PITCH_W-1:0] pitch_out,
    output logic               pitch_valid,
    output logic               busy,
    output logic               note_done,
    output logic               err_nostart
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [1:0]         attack;
        logic [1:0]         decay;
        logic [2:0]         length;
        logic [GAP_W-1:0]   gap;
        logic               rest;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_WAITS, S_PLAY, S_REST, S_GAP
    } state_t;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    cmd_t             r_cur;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_wcnt;
    logic [9:0]       r_rcnt;
    logic [GAP_W-1:0] r_gcnt;
    logic             r_err;
    logic             w_err_set;
    logic             w_push;
    logic             w_pop;
    cmd_t             w_cmd_in;

    assign w_cmd_in = '{pitch: cmd_pitch, attack: cmd_attack, decay: cmd_decay,
                        length: cmd_length, gap: cmd_gap, rest: cmd_rest};

    assign cmd_ready = (r_count < (AW+1)'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge note_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // Queued entries are dropped on reset simply by clearing the pointers and count.
    always_ff @(posedge note_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = r_cur.rest ? S_REST : S_TRIG;
            S_TRIG:  w_state_nxt = S_WAITS;
            S_WAITS: begin
                if (env_enable) begin
                    w_state_nxt = S_PLAY;
                end else if (r_wcnt == 2'd2) begin
                    w_state_nxt = S_GAP;
                    w_err_set   = 1'b1;
                end
            end
            S_PLAY:  if (!env_enable) w_state_nxt = S_GAP;
            S_REST:  if (r_rcnt == 10'd1) w_state_nxt = S_GAP;
            S_GAP:   if (r_gcnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fields are captured on the pop so they are already stable during LOAD, one cycle ahead of the trigger.
    always_ff @(posedge note_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_gcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_cur <= r_mem[r_rd_ptr];
            if (r_state == S_TRIG)       r_wcnt <= '0;
            else if (r_state == S_WAITS) r_wcnt <= r_wcnt + 2'd1;
            if (r_state == S_LOAD)       r_rcnt <= (10'd2 << r_cur.length) + 10'd1;
            else if (r_state == S_REST)  r_rcnt <= r_rcnt - 10'd1;
            if (w_state_nxt == S_GAP && r_state != S_GAP) r_gcnt <= r_cur.gap;
            else if (r_state == S_GAP && r_gcnt != '0)    r_gcnt <= r_gcnt - 1'b1;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign env_attack  = r_cur.attack;
    assign env_decay   = r_cur.decay;
    assign env_length  = r_cur.length;
    assign pitch_out   = r_cur.pitch;
    assign env_trig    = (r_state == S_TRIG);
    assign pitch_valid = (r_state == S_PLAY);
    assign busy        = (r_state != S_IDLE);
    assign note_done   = (r_state == S_GAP) && (r_gcnt == '0);
    assign err_nostart = r_err;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: timeline model of each note plus directed scenarios with literal timing checks.
module tb_note_sequencer;
    localparam int DEPTH = 4;

    logic       note_clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_pitch = '0;
    logic [1:0] cmd_attack = '0;
    logic [1:0] cmd_decay = '0;
    logic [2:0] cmd_length = '0;
    logic [3:0] cmd_gap = '0;
    logic       cmd_rest = 1'b0;
    logic [1:0] env_attack;
    logic [1:0] env_decay;
    logic [2:0] env_length;
    logic       env_trig;
    logic       env_enable = 1'b0;
    logic [7:0] pitch_out;
    logic       pitch_valid;
    logic       busy;
    logic       note_done;
    logic       err_nostart;

    note_sequencer #(.DEPTH(DEPTH), .PITCH_W(8), .GAP_W(4)) dut (
        .note_clk(note_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pitch(cmd_pitch), .cmd_attack(cmd_attack), .cmd_decay(cmd_decay),
        .cmd_length(cmd_length), .cmd_gap(cmd_gap), .cmd_rest(cmd_rest),
        .env_attack(env_attack), .env_decay(env_decay), .env_length(env_length),
        .env_trig(env_trig), .env_enable(env_enable),
        .pitch_out(pitch_out), .pitch_valid(pitch_valid),
        .busy(busy), .note_done(note_done), .err_nostart(err_nostart)
    );

    always #5 note_clk = ~note_clk;

    int errors = 0;
    int checks = 0;
    int tcyc   = 0;

    always @(posedge note_clk) tcyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tcyc, act, exp);
        end
    endtask

    // Envelope stand-in: enable stays high for a pitch-dependent number of cycles after a trigger.
    function automatic int env_dur(input logic [7:0] p);
        if (p[7]) return 0;
        if (p[3:0] == 4'd0) return 9;
        return int'(p[3:0]);
    endfunction

    typedef struct packed {
        logic [7:0] pitch;
        logic [1:0] atk;
        logic [1:0] dec;
        logic [2:0] len;
        logic [3:0] gap;
        logic       rest;
    } mcmd_t;

    // Model: each popped note gets an absolute timeline computed from its fields.
    mcmd_t mq[$];
    mcmd_t m_cur;
    mcmd_t m_lat;
    bit    m_active = 0;
    bit    m_pop = 0;
    bit    m_err = 0;
    int    m_c = 0, m_p = 0, m_E = 0, m_R = 0, m_done = 0;

    always @(posedge note_clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_pop    = 0;
            m_err    = 0;
            m_lat    = '0;
        end else begin
            bit push_ok;
            push_ok = cmd_valid && (mq.size() < DEPTH);
            if (m_pop) begin
                mq.delete(0);
                m_pop = 0;
            end
            if (push_ok)
                mq.push_back('{pitch: cmd_pitch, atk: cmd_attack, dec: cmd_decay,
                               len: cmd_length, gap: cmd_gap, rest: cmd_rest});
            m_c++;
            if (m_active && m_c > m_done) m_active = 0;
            if (!m_active && mq.size() > 0) begin
                int gs;
                m_cur    = mq[0];
                m_p      = m_c;
                m_active = 1;
                m_pop    = 1;
                m_E      = env_dur(m_cur.pitch);
                m_R      = (2 << m_cur.len) + 1;
                if (m_cur.rest)  gs = m_p + 2 + m_R;
                else if (m_E > 0) gs = m_p + 4 + m_E;
                else             gs = m_p + 6;
                m_done = gs + int'(m_cur.gap);
            end
            if (m_active && m_c == m_p + 1) m_lat = m_cur;
            if (m_active && !m_cur.rest && m_E == 0 && m_c == m_p + 6) m_err = 1;
        end
    end

    // Monitor, envelope trigger capture and per-cycle comparison against the model.
    int   trig_q[$];
    int   tp_q[$];
    int   done_q[$];
    int   fall_q[$];
    int   pv_cnt = 0, busy_cnt = 0, err_rise = -1, rdy_low_first = -1;
    logic en_prev = 0, err_prev = 0;
    bit   env_arm = 0;
    int   env_arm_len = 0, env_left = 0;

    always @(negedge note_clk) begin
        if (!rst) begin
            bit e_trig, e_pv, e_done, e_busy;
            e_trig = m_active && !m_cur.rest && m_c == m_p + 2;
            e_pv   = m_active && !m_cur.rest && m_E > 0 && m_c >= m_p + 4 && m_c <= m_p + 3 + m_E;
            e_done = m_active && m_c == m_done;
            e_busy = m_active && m_c >= m_p + 1;
            chk("m_cmd_ready",   int'(cmd_ready),   int'(mq.size() < DEPTH));
            chk("m_env_trig",    int'(env_trig),    int'(e_trig));
            chk("m_pitch_valid", int'(pitch_valid), int'(e_pv));
            chk("m_note_done",   int'(note_done),   int'(e_done));
            chk("m_busy",        int'(busy),        int'(e_busy));
            chk("m_err_nostart", int'(err_nostart), int'(m_err));
            chk("m_pitch_out",   int'(pitch_out),   int'(m_lat.pitch));
            chk("m_env_params",  int'({env_attack, env_decay, env_length}),
                                 int'({m_lat.atk, m_lat.dec, m_lat.len}));
            if (env_trig) begin
                trig_q.push_back(tcyc);
                tp_q.push_back(int'(pitch_out));
                env_arm     = 1;
                env_arm_len = env_dur(pitch_out);
            end
            if (pitch_valid) pv_cnt++;
            if (busy) busy_cnt++;
            if (note_done) done_q.push_back(tcyc);
            if (en_prev && !env_enable) fall_q.push_back(tcyc);
            if (err_nostart && !err_prev) err_rise = tcyc;
            if (!cmd_ready && rdy_low_first < 0) rdy_low_first = tcyc;
        end
        en_prev  = env_enable;
        err_prev = err_nostart;
    end

    initial forever begin
        @(posedge note_clk);
        #1;
        if (rst) begin
            env_arm = 0; env_left = 0; env_enable = 0;
        end else begin
            if (env_arm) begin
                env_left = env_arm_len;
                env_arm  = 0;
            end
            env_enable = (env_left > 0);
            if (env_left > 0) env_left--;
        end
    end

    task automatic sync();
        @(posedge note_clk);
        #1;
    endtask

    task automatic clear_mon();
        trig_q.delete(); tp_q.delete(); done_q.delete(); fall_q.delete();
        pv_cnt = 0; busy_cnt = 0; err_rise = -1; rdy_low_first = -1;
    endtask

    task automatic push(input logic [7:0] p, input logic [1:0] a, input logic [1:0] d,
                        input logic [2:0] l, input logic [3:0] g, input logic r, output int pc);
        logic rdy;
        cmd_pitch = p; cmd_attack = a; cmd_decay = d; cmd_length = l; cmd_gap = g; cmd_rest = r;
        cmd_valid = 1'b1;
        pc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge note_clk);
            rdy = cmd_ready;
            sync();
            if (rdy) begin
                pc = tcyc - 1;
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        chk("push_timeout", 0, 1);
    endtask

    task automatic wait_done(input int n, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge note_clk);
            if (done_q.size() >= n) ok = 1;
        end
        if (!ok) chk("note_done_timeout", done_q.size(), n);
        sync();
    endtask

    task automatic wait_pv(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge note_clk);
            if (pitch_valid) ok = 1;
        end
        if (!ok) chk("pitch_valid_timeout", 0, 1);
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    int pc, pc_a, pc4, pc5;
    int exp_pitch [6];

    initial begin
        exp_pitch[0] = 'h1F; exp_pitch[1] = 'h11; exp_pitch[2] = 'h12;
        exp_pitch[3] = 'h13; exp_pitch[4] = 'h14; exp_pitch[5] = 'h15;

        // Reset state
        sync(); sync();
        @(negedge note_clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_trig_pv_done", int'({env_trig, pitch_valid, note_done}), 0);
        chk("rst_err", int'(err_nostart), 0);
        chk("rst_pitch_out", int'(pitch_out), 0);
        sync();
        rst = 1'b0;
        sync();

        // Single note, envelope high 9 cycles
        clear_mon();
        push(8'h40, 2'd1, 2'd1, 3'd2, 4'd0, 1'b0, pc);
        wait_done(1, 100);
        @(negedge note_clk);
        chk("t1_trig_count", trig_q.size(), 1);
        if (trig_q.size() > 0) chk("t1_push_to_trig", trig_q[0] - pc, 3);
        chk("t1_pv_cycles", pv_cnt, 9);
        chk("t1_done_count", done_q.size(), 1);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_env_params", int'({env_attack, env_decay, env_length}), 'b01_01_010);
        sync();

        // Queue fills while the first note plays
        clear_mon();
        push(8'h1F, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, pc_a);
        wait_pv(20);
        push(8'h11, 2'd1, 2'd2, 3'd3, 4'd0, 1'b0, pc);
        push(8'h12, 2'd2, 2'd3, 3'd4, 4'd0, 1'b0, pc);
        push(8'h13, 2'd3, 2'd0, 3'd5, 4'd0, 1'b0, pc);
        push(8'h14, 2'd0, 2'd1, 3'd6, 4'd0, 1'b0, pc4);
        push(8'h15, 2'd1, 2'd1, 3'd7, 4'd0, 1'b0, pc5);
        chk("t2_ready_low_after_4th", rdy_low_first, pc4 + 1);
        if (done_q.size() > 0) chk("t2_5th_accept_after_pop", pc5, done_q[0] + 2);
        wait_done(6, 400);
        chk("t2_trig_count", trig_q.size(), 6);
        for (int i = 0; i < 6 && i < tp_q.size(); i++) chk("t2_pitch_order", tp_q[i], exp_pitch[i]);
        if (trig_q.size() > 1 && fall_q.size() > 0) chk("t2_turnaround_gap0", trig_q[1] - fall_q[0] - 1, 3);

        // Rest command: length 1, gap 2
        clear_mon();
        push(8'h22, 2'd0, 2'd0, 3'd1, 4'd2, 1'b1, pc);
        wait_done(1, 100);
        chk("t3_no_trig", trig_q.size(), 0);
        chk("t3_no_pv", pv_cnt, 0);
        if (done_q.size() > 0) chk("t3_pop_to_done", done_q[0] - (pc + 1), 9);
        chk("t3_busy_cycles", busy_cnt, 9);

        // Envelope never starts, next command still plays
        clear_mon();
        push(8'h80, 2'd2, 2'd3, 3'd4, 4'd0, 1'b0, pc);
        push(8'h45, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, pc);
        wait_done(2, 200);
        if (trig_q.size() > 0) chk("t4_err_after_trig", err_rise - trig_q[0], 4);
        chk("t4_trig_count", trig_q.size(), 2);
        chk("t4_pv_second", pv_cnt, 5);
        @(negedge note_clk);
        chk("t4_err_sticky", int'(err_nostart), 1);
        sync();

        // Reset while playing with two commands queued
        clear_mon();
        push(8'h1F, 2'd3, 2'd3, 3'd7, 4'd0, 1'b0, pc);
        wait_pv(20);
        push(8'h31, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, pc);
        push(8'h32, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, pc);
        @(negedge note_clk);
        chk("t5_err_still_set", int'(err_nostart), 1);
        chk("t5_pv_before_rst", int'(pitch_valid), 1);
        sync();
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ready", int'(cmd_ready), 1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_trig_pv_done", int'({env_trig, pitch_valid, note_done}), 0);
        chk("t5_rst_err", int'(err_nostart), 0);
        chk("t5_rst_params", int'({pitch_out, env_attack, env_decay, env_length}), 0);
        sync(); sync();
        rst = 1'b0;
        clear_mon();
        repeat (30) sync();
        chk("t5_no_trig_after", trig_q.size(), 0);
        chk("t5_idle_after", busy_cnt, 0);

        // Gap of 15 between two notes
        clear_mon();
        push(8'h43, 2'd1, 2'd0, 3'd1, 4'd15, 1'b0, pc);
        push(8'h44, 2'd0, 2'd1, 3'd2, 4'd0, 1'b0, pc);
        wait_done(2, 200);
        if (trig_q.size() > 1 && fall_q.size() > 0) chk("t6_gap15_turnaround", trig_q[1] - fall_q[0] - 1, 18);
        chk("t6_pv_cycles", pv_cnt, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
